spike_rhythm_classifier: RTL and testbench

- Downstream of the two AdEx neurons in the ECG chain. Consumes the spike train of the positive-current neuron and the spike train of the inverted-current neuron.
- Turns accepted positive spikes into beat events and measures the R-R interval (in clock cycles) between consecutive beats.
- Keeps a running average interval and classifies each beat as normal, premature or late. Each beat is also tagged if the inverted-channel neuron fired during that beat.

---
 rtl/spike_rhythm_classifier.sv | 257 +++++++++++++++++++++++++
 tb/tb_spike_rhythm_classifier.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rhythm_classifier.sv
// -----------------------------------------------------------------------------
// spike_rhythm_classifier
//
// Purpose:
//   Turns the spike train of the positive-current AdEx neuron into beat events,
//   measures the R-R interval (in clock cycles) between consecutive beats,
//   keeps an exponentially weighted running average of that interval and
//   classifies every beat as normal / premature / late relative to the
//   average. Each beat is also tagged when the inverted-current neuron fired
//   since the previous beat.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   spike        in   spike from the positive-current neuron (may stay high)
//   spike_neg    in   spike from the inverted-current neuron
//   beat_valid   out  one-cycle pulse per accepted beat
//   rr_interval  out  interval of the beat flagged by beat_valid (held)
//   rr_avg       out  running average interval (held between beats)
//   beat_type    out  00 normal, 01 premature, 10 late, 11 first/unclassified
//   neg_seen     out  spike_neg rising edge since previous beat (held)
//   timeout      out  one-cycle pulse when the interval counter hits RR_MAX
// -----------------------------------------------------------------------------
module spike_rhythm_classifier #(
    parameter int CNT_W     = 16,
    parameter int REFRACT   = 40,
    parameter int RR_MAX    = 2000,
    parameter int AVG_SHIFT = 3,
    parameter int TOL_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike,
    input  logic             spike_neg,
    output logic             beat_valid,
    output logic [CNT_W-1:0] rr_interval,
    output logic [CNT_W-1:0] rr_avg,
    output logic [1:0]       beat_type,
    output logic             neg_seen,
    output logic             timeout
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FIRST_REF = 3'd1,
        FIRST_ARM = 3'd2,
        REFR      = 3'd3,
        ARMED     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] REFRACT_C = CNT_W'(REFRACT);
    localparam logic [CNT_W-1:0] RR_MAX_C  = CNT_W'(RR_MAX);

    localparam logic [1:0] BT_NORMAL    = 2'b00;
    localparam logic [1:0] BT_PREMATURE = 2'b01;
    localparam logic [1:0] BT_LATE      = 2'b10;
    localparam logic [1:0] BT_FIRST     = 2'b11;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           state_reg,       state_next;
    logic             spike_d_reg;
    logic             spike_neg_d_reg;
    logic [CNT_W-1:0] cnt_reg,         cnt_next;
    logic             neg_acc_reg,     neg_acc_next;
    logic             beat_valid_reg,  beat_valid_next;
    logic             timeout_reg,     timeout_next;
    logic [CNT_W-1:0] rr_interval_reg, rr_interval_next;
    logic [CNT_W-1:0] rr_avg_reg,      rr_avg_next;
    logic [1:0]       beat_type_reg,   beat_type_next;
    logic             neg_seen_reg,    neg_seen_next;

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic spike_edge;
    logic neg_edge;

    assign spike_edge = spike & ~spike_d_reg;
    assign neg_edge   = spike_neg & ~spike_neg_d_reg;

    // ------------------------------------------------------------------
    // Classification and average arithmetic.
    // Everything is widened by one bit so avg + tol cannot wrap and the
    // signed difference rr - avg keeps its sign.
    // ------------------------------------------------------------------
    logic        [CNT_W:0] rr_ext;
    logic        [CNT_W:0] avg_ext;
    logic        [CNT_W:0] tol_ext;
    logic        [CNT_W:0] band_lo;
    logic        [CNT_W:0] band_hi;
    logic signed [CNT_W:0] diff;
    logic signed [CNT_W:0] step;
    logic        [CNT_W-1:0] avg_upd;
    logic        [1:0]       class_type;

    always_comb begin
        rr_ext  = {1'b0, cnt_reg};
        avg_ext = {1'b0, rr_avg_reg};
        tol_ext = {1'b0, (rr_avg_reg >> TOL_SHIFT)};
        band_lo = avg_ext - tol_ext;
        band_hi = avg_ext + tol_ext;

        // Arithmetic shift floors toward minus infinity, so a shorter
        // interval pulls the average down by at least one count.
        diff    = $signed(rr_ext) - $signed(avg_ext);
        step    = diff >>> AVG_SHIFT;
        avg_upd = CNT_W'($signed(avg_ext) + step);

        // Band edges are inclusive to normal.
        if (rr_ext < band_lo) begin
            class_type = BT_PREMATURE;
        end else if (rr_ext > band_hi) begin
            class_type = BT_LATE;
        end else begin
            class_type = BT_NORMAL;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and beat-output logic
    // ------------------------------------------------------------------
    logic accept;

    always_comb begin
        state_next       = state_reg;
        accept           = 1'b0;
        rr_interval_next = rr_interval_reg;
        rr_avg_next      = rr_avg_reg;
        beat_type_next   = beat_type_reg;

        case (state_reg)
            IDLE: begin
                // Very first beat has no predecessor, so no interval.
                if (spike_edge) begin
                    accept           = 1'b1;
                    rr_interval_next = '0;
                    beat_type_next   = BT_FIRST;
                    state_next       = FIRST_REF;
                end
            end
            FIRST_REF: begin
                if (cnt_reg == REFRACT_C) begin
                    state_next = FIRST_ARM;
                end
            end
            FIRST_ARM: begin
                // First real interval seeds the average directly.
                if (spike_edge) begin
                    accept           = 1'b1;
                    rr_interval_next = cnt_reg;
                    rr_avg_next      = cnt_reg;
                    beat_type_next   = BT_FIRST;
                    state_next       = REFR;
                end
            end
            REFR: begin
                if (cnt_reg == REFRACT_C) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (spike_edge) begin
                    accept           = 1'b1;
                    rr_interval_next = cnt_reg;
                    rr_avg_next      = avg_upd;
                    beat_type_next   = class_type;
                    state_next       = REFR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Interval counter, neg accumulator and pulse outputs
    // ------------------------------------------------------------------
    logic armed_window;

    assign armed_window = (state_reg == FIRST_ARM) || (state_reg == ARMED);

    always_comb begin
        cnt_next        = cnt_reg;
        neg_acc_next    = neg_acc_reg;
        neg_seen_next   = neg_seen_reg;
        beat_valid_next = accept;
        timeout_next    = 1'b0;

        if (accept) begin
            // cnt counts cycles since the beat edge, so the value sampled
            // at the next beat edge is exactly the edge-to-edge distance.
            cnt_next      = {{(CNT_W-1){1'b0}}, 1'b1};
            // A spike_neg edge coincident with the beat belongs to it.
            neg_seen_next = neg_acc_reg | neg_edge;
            neg_acc_next  = 1'b0;
        end else begin
            if (cnt_reg != CNT_SAT) begin
                cnt_next = cnt_reg + 1'b1;
            end
            neg_acc_next = neg_acc_reg | neg_edge;
            // Only the transition onto RR_MAX fires; the counter passes
            // this value once per interval, giving a single pulse.
            if (armed_window && (cnt_next == RR_MAX_C) && (cnt_reg != RR_MAX_C)) begin
                timeout_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_d_reg     <= 1'b0;
            spike_neg_d_reg <= 1'b0;
            cnt_reg         <= '0;
            neg_acc_reg     <= 1'b0;
            beat_valid_reg  <= 1'b0;
            timeout_reg     <= 1'b0;
            rr_interval_reg <= '0;
            rr_avg_reg      <= '0;
            beat_type_reg   <= BT_FIRST;
            neg_seen_reg    <= 1'b0;
        end else begin
            spike_d_reg     <= spike;
            spike_neg_d_reg <= spike_neg;
            cnt_reg         <= cnt_next;
            neg_acc_reg     <= neg_acc_next;
            beat_valid_reg  <= beat_valid_next;
            timeout_reg     <= timeout_next;
            rr_interval_reg <= rr_interval_next;
            rr_avg_reg      <= rr_avg_next;
            beat_type_reg   <= beat_type_next;
            neg_seen_reg    <= neg_seen_next;
        end
    end

    assign beat_valid  = beat_valid_reg;
    assign timeout     = timeout_reg;
    assign rr_interval = rr_interval_reg;
    assign rr_avg      = rr_avg_reg;
    assign beat_type   = beat_type_reg;
    assign neg_seen    = neg_seen_reg;

endmodule

// File: tb/tb_spike_rhythm_classifier.sv
// -----------------------------------------------------------------------------
// tb_spike_rhythm_classifier
//
// Drives directed and randomized spike trains into spike_rhythm_classifier and
// checks every output on every falling clock edge against a behavioural model
// that works in terms of "cycles since the last accepted beat" and "number of
// beats seen", plus literal expectations for hand-computed scenarios.
// -----------------------------------------------------------------------------
module tb_spike_rhythm_classifier;

    localparam int REFRACT = 40;
    localparam int RR_MAX  = 2000;
    localparam int SAT     = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spike = 1'b0;
    logic        spike_neg = 1'b0;
    logic        beat_valid;
    logic [15:0] rr_interval;
    logic [15:0] rr_avg;
    logic [1:0]  beat_type;
    logic        neg_seen;
    logic        timeout;

    spike_rhythm_classifier dut (
        .clk         (clk),
        .rst         (rst),
        .spike       (spike),
        .spike_neg   (spike_neg),
        .beat_valid  (beat_valid),
        .rr_interval (rr_interval),
        .rr_avg      (rr_avg),
        .beat_type   (beat_type),
        .neg_seen    (neg_seen),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int m_since;    // cycles since last accepted beat edge
    int m_nbeats;   // beats accepted since reset
    int m_avg;
    bit m_nacc, m_ps, m_pn;
    int e_bv = 0, e_to = 0, e_rr = 0, e_bt = 3, e_ns = 0;

    task automatic model_reset();
        m_since  = 0;
        m_nbeats = 0;
        m_avg    = 0;
        m_nacc   = 0;
        m_ps     = 0;
        m_pn     = 0;
        e_bv     = 0;
        e_to     = 0;
        e_rr     = 0;
        e_bt     = 3;
        e_ns     = 0;
    endtask

    task automatic model_step();
        bit se, ne;
        int rr, tol, d, st;
        se = spike && !m_ps;
        ne = spike_neg && !m_pn;
        m_ps = spike;
        m_pn = spike_neg;
        e_bv = 0;
        e_to = 0;
        if (se && (m_nbeats == 0 || m_since > REFRACT)) begin
            rr = (m_since > SAT) ? SAT : m_since;
            if (m_nbeats == 0) begin
                e_rr = 0;
                e_bt = 3;
            end else if (m_nbeats == 1) begin
                e_rr  = rr;
                m_avg = rr;
                e_bt  = 3;
            end else begin
                e_rr = rr;
                tol  = m_avg / 4;
                if (rr < m_avg - tol)      e_bt = 1;
                else if (rr > m_avg + tol) e_bt = 2;
                else                       e_bt = 0;
                d  = rr - m_avg;
                st = (d >= 0) ? d / 8 : -((-d + 7) / 8);   // floor(d/8)
                m_avg = (m_avg + st) % 65536;
            end
            e_ns     = (m_nacc || ne) ? 1 : 0;
            m_nacc   = 0;
            m_since  = 1;
            m_nbeats = (m_nbeats < 2) ? m_nbeats + 1 : 2;
            e_bv     = 1;
        end else begin
            m_nacc = m_nacc || ne;
            if (m_nbeats >= 1 && m_since == RR_MAX - 1) e_to = 1;
            if (m_since < SAT) m_since++;
        end
    endtask

    initial model_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // ------------------------------------------------------------------
    // Cycle-by-cycle compare and pulse counters
    // ------------------------------------------------------------------
    int to_count = 0;
    int bv_count = 0;

    always @(negedge clk) begin
        check("beat_valid",  int'(beat_valid),  e_bv);
        check("timeout",     int'(timeout),     e_to);
        check("rr_interval", int'(rr_interval), e_rr);
        check("rr_avg",      int'(rr_avg),      m_avg);
        check("beat_type",   int'(beat_type),   e_bt);
        check("neg_seen",    int'(neg_seen),    e_ns);
        if (timeout)    to_count <= to_count + 1;
        if (beat_valid) bv_count <= bv_count + 1;
    end

    // ------------------------------------------------------------------
    // Stimulus: one spike edge now, held w cycles, next call g cycles later.
    // spike_neg pulses for one cycle at offset neg_at (negative: none).
    // Literal expectations are checked one cycle after the edge; -1 skips.
    // ------------------------------------------------------------------
    task automatic hit(input int g, input int w, input int neg_at,
                       input int ev, input int err, input int eavg,
                       input int ebt, input int ens);
        for (int i = 0; i < g; i++) begin
            spike     = (i < w);
            spike_neg = (neg_at >= 0) && (i == neg_at);
            @(negedge clk);
            if (i == 0) begin
                if (ev  >= 0) check("lit_beat_valid",  int'(beat_valid),  ev);
                if (err >= 0) check("lit_rr_interval", int'(rr_interval), err);
                if (eavg >= 0) check("lit_rr_avg",     int'(rr_avg),      eavg);
                if (ebt >= 0) check("lit_beat_type",   int'(beat_type),   ebt);
                if (ens >= 0) check("lit_neg_seen",    int'(neg_seen),    ens);
                $display("[TB] t=%0t edge: valid=%0d rr=%0d avg=%0d type=%0d neg=%0d",
                         $time, beat_valid, rr_interval, rr_avg, beat_type, neg_seen);
            end
        end
        spike     = 1'b0;
        spike_neg = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_beat_valid"},  int'(beat_valid),  0);
        check({tag, "_timeout"},     int'(timeout),     0);
        check({tag, "_rr_interval"}, int'(rr_interval), 0);
        check({tag, "_rr_avg"},      int'(rr_avg),      0);
        check({tag, "_beat_type"},   int'(beat_type),   3);
        check({tag, "_neg_seen"},    int'(neg_seen),    0);
    endtask

    int to_base, bv_base;
    int g, w, na, r;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Steady 800 rhythm, then a premature beat.
        hit(800, 1, -1, 1,   0,   0, 3, 0);
        hit(800, 1, -1, 1, 800, 800, 3, -1);
        hit(800, 1, -1, 1, 800, 800, 0, -1);
        hit(500, 1, -1, 1, 800, 800, 0, -1);
        hit(10,  1, -1, 1, 500, 762, 1, -1);
        // Refractory: +10 and +39 ignored, +45 accepted.
        hit(29,  1, -1, 0, -1, -1, -1, -1);
        hit(6,   1, -1, 0, -1, -1, -1, -1);
        hit(800, 1, -1, 1, 45, 672, 1, -1);
        // Missed beat: single timeout at 2000, late beat at 2300.
        to_base = to_count;
        hit(2300, 1, -1, 1, 800, 688, 0, -1);
        bv_base = bv_count;
        hit(800, 300, -1, 1, 2300, 889, 2, -1);
        check("timeout_pulses", to_count - to_base, 1);
        check("held_spike_beats", bv_count - bv_base, 1);
        // spike_neg tagging.
        hit(800, 1, 400, 1, 800, -1, 0, 0);
        hit(800, 1, -1,  1, 800, -1, -1, 1);
        hit(800, 1, -1,  1, 800, -1, -1, 0);
        hit(800, 1, 0,   1, 800, -1, -1, 1);

        // Asynchronous reset with a spike edge pending in ARMED.
        spike = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        spike = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Restart; exercise both inclusive band edges.
        hit(800, 1, -1, 1,   0,   0, 3, -1);
        hit(800, 1, -1, 1, 800, 800, 3, -1);
        hit(600, 1, -1, 1, 800, 800, 0, -1);
        hit(968, 1, -1, 1, 600, 775, 0, -1);
        hit(800, 1, -1, 1, 968, 799, 0, -1);

        // Randomized rhythm.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      g = $urandom_range(2, 60);
            else if (r < 93) g = $urandom_range(500, 1100);
            else             g = $urandom_range(1950, 2300);
            w  = $urandom_range(1, (g - 1 < 4) ? g - 1 : 4);
            na = ($urandom_range(0, 2) == 0) ? $urandom_range(0, g - 1) : -1;
            hit(g, w, na, -1, -1, -1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
